muldiv_unit: RTL and testbench

Iterative RV32M multiply/divide unit for the single-cycle core. Sits directly downstream of the register file: it takes the two register read values (RD1 → `rs1_val`, RD2 → `rs2_val`) and returns a 32-bit result on the write-data path (WD3). While it is working, `busy` stalls PC update and register write-enable. It uses a fixed-latency shift-add multiplier and a restoring divider, both running on operand magnitudes, followed by a sign-fix step.

---
 rtl/muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [5:0]      LAST_CNT = 6'(ITER - 1);
    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    state_t              state_q, state_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic                div_zero_q, div_zero_d;
    logic                ovf_q, ovf_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [5:0]          cnt_q, cnt_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     result_q, result_d;

    // Operand decode at accept time
    logic            is_div_in;
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    // Datapath for one iteration and for the final sign fix
    logic [2*XLEN-1:0] mul_add;
    logic [2*XLEN-1:0] mul_step;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     trial;
    logic [2*XLEN-1:0] div_step;
    logic [2*XLEN-1:0] prod_neg;
    logic [XLEN-1:0]   quo, rem;

    // Signedness, magnitudes and per-iteration shift-add / restoring-subtract
    always_comb begin
        is_div_in = op[2];
        a_signed  = is_div_in ? ~op[0] : (op != 3'b011);
        b_signed  = is_div_in ? ~op[0] : ~op[1];
        a_neg     = a_signed & rs1_val[XLEN-1];
        b_neg     = b_signed & rs2_val[XLEN-1];
        a_mag     = a_neg ? (~rs1_val + 1'b1) : rs1_val;
        b_mag     = b_neg ? (~rs2_val + 1'b1) : rs2_val;

        mul_add   = {{XLEN{1'b0}}, a_q} << cnt_q[4:0];
        mul_step  = b_q[cnt_q[4:0]] ? (acc_q + mul_add) : acc_q;

        // Dividend bits are fed MSB first; ~cnt equals 31-cnt for a 5-bit count.
        rem_sh    = {acc_q[2*XLEN-1:XLEN], a_q[~cnt_q[4:0]]};
        trial     = rem_sh - {1'b0, b_q};
        div_step  = trial[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                : {trial[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};

        prod_neg  = ~acc_q + 1'b1;
        quo       = acc_q[XLEN-1:0];
        rem       = acc_q[2*XLEN-1:XLEN];
    end

    // Next-state logic for the IDLE/CALC/FIX/DONE sequencer and its registered outputs
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        div_zero_d = div_zero_q;
        ovf_d      = ovf_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_CALC;
                    op_d       = op;
                    a_d        = a_mag;
                    b_d        = b_mag;
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    div_zero_d = (rs2_val == '0);
                    ovf_d      = (op == 3'b100 || op == 3'b110) &&
                                 (rs1_val == INT_MIN) && (rs2_val == ALL_ONES);
                    acc_d      = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            end
            S_CALC: begin
                acc_d = op_q[2] ? div_step : mul_step;
                if (cnt_q == LAST_CNT) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_FIX: begin
                state_d = S_DONE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                case (op_q)
                    3'b000:
                        result_d = neg_res_q ? prod_neg[XLEN-1:0] : acc_q[XLEN-1:0];
                    3'b001, 3'b010, 3'b011:
                        result_d = neg_res_q ? prod_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
                    3'b100, 3'b101: begin
                        if (div_zero_q)     result_d = ALL_ONES;
                        else if (ovf_q)     result_d = INT_MIN;
                        else if (neg_res_q) result_d = ~quo + 1'b1;
                        else                result_d = quo;
                    end
                    default: begin
                        // On a zero divisor the remainder holds |rs1|; re-applying the
                        // dividend sign reproduces rs1 exactly.
                        if (ovf_q)          result_d = '0;
                        else if (neg_rem_q) result_d = ~rem + 1'b1;
                        else                result_d = rem;
                    end
                endcase
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            ovf_q      <= 1'b0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            div_zero_q <= div_zero_d;
            ovf_q      <= ovf_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_assert = 0;
    int n_fail   = 0;

    muldiv_unit #(.XLEN(32), .ITER(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with start already driven high. Returns edges from the
    // accept edge (counted as 1) to the edge that raises done, and busy cycles seen.
    // glitch_at > 0 pulses start with unrelated operands at that cycle.
    task automatic wait_done(input int glitch_at, output int lat, output int busy_cycles,
                             output logic got, output logic overlap);
        lat = 1;
        busy_cycles = 0;
        overlap = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < 80) begin
            if (busy) busy_cycles++;
            if (lat == glitch_at) begin
                start = 1'b1; op = 3'b101; rs1_val = 32'd1000; rs2_val = 32'd3;
            end else begin
                start = 1'b0; rs1_val = $urandom; rs2_val = $urandom;
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        start = 1'b0;
        got = done;
        overlap = busy & done;
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int glitch_at);
        int   lat, bc;
        logic got, ov;
        op = o; rs1_val = a; rs2_val = b; start = 1'b1;
        wait_done(glitch_at, lat, bc, got, ov);
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_latency"}, lat, 32'd34);
        chk({tag, "_busy_done_overlap"}, 32'(ov), 32'd0);
        if (tag == "mul_neg") chk({tag, "_busy_cycles"}, bc, 32'd33);
    endtask

    initial begin
        int   lat, bc, n_done;
        logic got, ov;

        rst = 1'b1; start = 1'b0; op = 3'b000; rs1_val = '0; rs2_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul_neg", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
        @(negedge clk);
        chk("hold_done_low", 32'(done), 32'd0);
        chk("hold_result", result, 32'hFFFF_FFEB);

        run_op("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
        run_op("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
        run_op("mulhsu_m1", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op("div_neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 0);
        run_op("rem_neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0);
        run_op("divu_zero", 3'b101, 32'd45, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("remu_zero", 3'b111, 32'd45, 32'd0, 32'd45, 0);
        run_op("div_zero_neg", 3'b100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 0);
        run_op("rem_zero_neg", 3'b110, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 0);
        run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
        run_op("div_ignore_start", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 5);

        // Abort: accept at cycle 0, stray start at cycle 5, reset at cycle 10.
        op = 3'b101; rs1_val = 32'd100; rs2_val = 32'd7; start = 1'b1;
        @(posedge clk);
        n_done = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done) n_done++;
            start = (c == 5);
            if (c == 5) begin op = 3'b000; rs1_val = 32'd9; rs2_val = 32'd9; end
            rst = (c == 10);
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, 32'd0);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("abort_no_done", n_done, 32'd0);
        run_op("divu_after_abort", 3'b101, 32'd100, 32'd7, 32'd14, 0);

        // Back-to-back: second start issued while the first done is high.
        run_op("b2b_mul", 3'b000, 32'd3, 32'd5, 32'd15, 0);
        op = 3'b111; rs1_val = 32'd100; rs2_val = 32'd7; start = 1'b1;
        wait_done(0, lat, bc, got, ov);
        chk("b2b_remu_done_seen", 32'(got), 32'd1);
        chk("b2b_remu_result", result, 32'd2);
        chk("b2b_done_spacing", lat, 32'd34);
        chk("b2b_busy_cycles", bc, 32'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
